painterengine_gpu_dma_reader: RTL and testbench

AXI4 full read master that fetches a linear run of 32-bit words (pixels) from memory and presents them as a valid/next word stream to downstream GPU stages, ending at the DMA writer. Bursts are split on 64-byte boundaries and throttled by an internal FIFO, so at most one burst is outstanding and RREADY never has to drop mid-burst.

---
 rtl/painterengine_gpu_dma_pkg.sv | 44 ++++
 rtl/painterengine_gpu_dma_reader_if.sv | 39 +++
 rtl/painterengine_gpu_stream_fifo.sv | 53 +++++
 rtl/painterengine_gpu_dma_reader.sv | 196 +++++++++++++++++++
 tb/tb_painterengine_gpu_dma_reader.sv | 387 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/painterengine_gpu_dma_pkg.sv
// Shared definitions for the PainterEngine GPU DMA reader and writer:
// FSM state codes, error-type codes, timeout limit and fixed AXI fields.
package painterengine_gpu_dma_pkg;

  localparam logic [4:0] ST_IDLE           = 5'h01;
  localparam logic [4:0] ST_PARAM_CHECK    = 5'h02;
  localparam logic [4:0] ST_CALC           = 5'h03;
  localparam logic [4:0] ST_ADDRESS_READ   = 5'h04;
  localparam logic [4:0] ST_DATA_READ      = 5'h05;
  localparam logic [4:0] ST_DONE           = 5'h07;
  localparam logic [4:0] ST_ERR_ALIGN      = 5'h11;
  localparam logic [4:0] ST_ERR_LENGTH     = 5'h12;
  localparam logic [4:0] ST_ERR_AR_TIMEOUT = 5'h13;
  localparam logic [4:0] ST_ERR_R_TIMEOUT  = 5'h14;
  localparam logic [4:0] ST_ERR_RRESP      = 5'h15;
  localparam logic [4:0] ST_ERR_RLAST      = 5'h16;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_ALIGN      = 3'd1,
    ERR_LENGTH     = 3'd2,
    ERR_AR_TIMEOUT = 3'd3,
    ERR_R_TIMEOUT  = 3'd4,
    ERR_RRESP      = 3'd5,
    ERR_RLAST      = 3'd6
  } err_type_e;

  localparam int unsigned TIMEOUT_CYCLES  = 256;
  localparam int unsigned BURST_MAX_WORDS = 16;

  localparam logic       AXI_ID         = 1'b0;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic       AXI_LOCK       = 1'b0;
  localparam logic [3:0] AXI_CACHE      = 4'b0010;
  localparam logic [2:0] AXI_PROT       = 3'b000;
  localparam logic [3:0] AXI_QOS        = 4'b0000;

  // Error states encode their error type in the low three bits.
  function automatic err_type_e state_error_type(input logic [4:0] st);
    return st[4] ? err_type_e'(st[2:0]) : ERR_NONE;
  endfunction

endpackage

// File: rtl/painterengine_gpu_dma_reader_if.sv
// AXI4 read-address and read-data channels between the DMA reader and memory.
interface painterengine_gpu_dma_reader_if;

  logic        m_axi_arid;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arlock;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic [3:0]  m_axi_arqos;
  logic        m_axi_arvalid;
  logic        m_axi_arready;

  logic        m_axi_rid;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  modport master (
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
           m_axi_rready,
    input  m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
           m_axi_rvalid
  );

  modport slave (
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
           m_axi_rready,
    output m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
           m_axi_rvalid
  );

endinterface

// File: rtl/painterengine_gpu_stream_fifo.sv
// Synchronous word FIFO feeding the GPU stream; head word visible while non-empty.
module painterengine_gpu_stream_fifo #(
  parameter int unsigned PARAM_DEPTH = 16
) (
  input  logic                         i_wire_clock,
  input  logic                         i_wire_resetn,
  input  logic                         push,
  input  logic [31:0]                  push_data,
  input  logic                         pop,
  output logic [31:0]                  head,
  output logic                         valid,
  output logic [$clog2(PARAM_DEPTH):0] count
);

  localparam int unsigned AW = $clog2(PARAM_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(PARAM_DEPTH);

  logic [31:0]   mem [PARAM_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count_q != DEPTH_CNT);
  assign do_pop  = pop && (count_q != '0);
  assign valid   = (count_q != '0);
  assign count   = count_q;
  assign head    = valid ? mem[rd_ptr] : '0;

  // Storage array: written on accepted push only.
  always_ff @(posedge i_wire_clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/painterengine_gpu_dma_reader.sv
// AXI4 read master: fetches a linear run of words in bursts that never cross a
// 64-byte boundary, one burst outstanding, each burst issued only once the
// stream FIFO has room for all of it.
module painterengine_gpu_dma_reader
  import painterengine_gpu_dma_pkg::*;
#(
  parameter int unsigned PARAM_FIFO_DEPTH = 16
) (
  input  logic                           i_wire_clock,
  input  logic                           i_wire_resetn,
  input  logic                           i_wire_start,
  input  logic [31:0]                    i_wire_address,
  input  logic [31:0]                    i_wire_length,
  output logic                           o_wire_done,
  output logic                           o_wire_error,
  output logic [2:0]                     o_wire_error_type,
  output logic [31:0]                    o_wire_data,
  output logic                           o_wire_data_valid,
  input  logic                           i_wire_data_next,
  painterengine_gpu_dma_reader_if.master m_axi
);

  localparam int unsigned CW = $clog2(PARAM_FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FIFO_DEPTH_CNT = CW'(PARAM_FIFO_DEPTH);

  logic [4:0]    state_q;
  logic [31:0]   address_q;
  logic [31:0]   length_q;
  logic [31:0]   offset_q;
  logic [4:0]    burst_q;
  logic [4:0]    beat_q;
  logic [15:0]   timeout_q;
  logic          arvalid_q;
  logic [31:0]   araddr_q;
  logic [7:0]    arlen_q;
  logic          draining_q;

  logic          fifo_valid;
  logic [31:0]   fifo_head;
  logic [CW-1:0] fifo_count;

  logic [31:0]   word_addr;
  logic [4:0]    room;
  logic [31:0]   remaining;
  logic [4:0]    burst_calc;
  logic [CW-1:0] fifo_free;
  logic          space_ok;
  logic          rready;
  logic          r_hs;
  logic          is_last_beat;
  logic [31:0]   offset_next;
  logic [15:0]   timeout_next;
  logic          timeout_hit;
  logic          unused_rid;

  painterengine_gpu_stream_fifo #(
    .PARAM_DEPTH (PARAM_FIFO_DEPTH)
  ) u_fifo (
    .i_wire_clock  (i_wire_clock),
    .i_wire_resetn (i_wire_resetn),
    .push          (r_hs),
    .push_data     (m_axi.m_axi_rdata),
    .pop           (i_wire_data_next),
    .head          (fifo_head),
    .valid         (fifo_valid),
    .count         (fifo_count)
  );

  assign rready       = (state_q == ST_DATA_READ) && !draining_q;
  assign r_hs         = m_axi.m_axi_rvalid && rready;
  assign is_last_beat = (beat_q == burst_q - 5'd1);
  assign offset_next  = offset_q + {27'd0, burst_q};
  assign timeout_next = timeout_q + 16'd1;
  assign timeout_hit  = (timeout_next == 16'(TIMEOUT_CYCLES));
  assign unused_rid   = m_axi.m_axi_rid;

  // Next burst: up to the 64-byte boundary, capped by the words still owed.
  always_comb begin
    word_addr  = address_q + {offset_q[29:0], 2'b00};
    room       = 5'd16 - {1'b0, word_addr[5:2]};
    remaining  = length_q - offset_q;
    burst_calc = (remaining < {27'd0, room}) ? remaining[4:0] : room;
    fifo_free  = FIFO_DEPTH_CNT - fifo_count;
    space_ok   = ({{(32-CW){1'b0}}, fifo_free} >= {27'd0, burst_calc});
  end

  // Transfer sequencing, burst bookkeeping, response checking and timeouts.
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_q    <= ST_IDLE;
      address_q  <= '0;
      length_q   <= '0;
      offset_q   <= '0;
      burst_q    <= '0;
      beat_q     <= '0;
      timeout_q  <= '0;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      draining_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (i_wire_start) begin
            address_q  <= i_wire_address;
            length_q   <= i_wire_length;
            offset_q   <= '0;
            draining_q <= 1'b0;
            timeout_q  <= '0;
            state_q    <= ST_PARAM_CHECK;
          end
        end
        ST_PARAM_CHECK: begin
          timeout_q <= '0;
          if (address_q[1:0] != 2'b00)  state_q <= ST_ERR_ALIGN;
          else if (length_q == '0)      state_q <= ST_ERR_LENGTH;
          else                          state_q <= ST_CALC;
        end
        ST_CALC: begin
          if (space_ok) begin
            araddr_q  <= word_addr;
            arlen_q   <= {3'b000, burst_calc - 5'd1};
            burst_q   <= burst_calc;
            arvalid_q <= 1'b1;
            timeout_q <= '0;
            state_q   <= ST_ADDRESS_READ;
          end
        end
        ST_ADDRESS_READ: begin
          if (m_axi.m_axi_arready) begin
            arvalid_q <= 1'b0;
            beat_q    <= '0;
            timeout_q <= '0;
            state_q   <= ST_DATA_READ;
          end else if (timeout_hit) begin
            arvalid_q <= 1'b0;
            timeout_q <= '0;
            state_q   <= ST_ERR_AR_TIMEOUT;
          end else begin
            timeout_q <= timeout_next;
          end
        end
        ST_DATA_READ: begin
          // After the final burst RREADY stays low until the consumer empties the FIFO.
          if (draining_q) begin
            if (!fifo_valid) begin
              draining_q <= 1'b0;
              state_q    <= ST_DONE;
            end
          end else if (r_hs) begin
            timeout_q <= '0;
            if (m_axi.m_axi_rresp >= 2'b10) begin
              state_q <= ST_ERR_RRESP;
            end else if (m_axi.m_axi_rlast != is_last_beat) begin
              state_q <= ST_ERR_RLAST;
            end else if (is_last_beat) begin
              offset_q <= offset_next;
              beat_q   <= '0;
              if (offset_next >= length_q) draining_q <= 1'b1;
              else                         state_q    <= ST_CALC;
            end else begin
              beat_q <= beat_q + 5'd1;
            end
          end else if (timeout_hit) begin
            timeout_q <= '0;
            state_q   <= ST_ERR_R_TIMEOUT;
          end else begin
            timeout_q <= timeout_next;
          end
        end
        default: begin
          if (!state_q[4]) state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_wire_done       = (state_q == ST_DONE);
  assign o_wire_error      = state_q[4];
  assign o_wire_error_type = state_error_type(state_q);
  assign o_wire_data       = fifo_head;
  assign o_wire_data_valid = fifo_valid;

  assign m_axi.m_axi_arid    = AXI_ID;
  assign m_axi.m_axi_araddr  = araddr_q;
  assign m_axi.m_axi_arlen   = arlen_q;
  assign m_axi.m_axi_arsize  = AXI_SIZE_4B;
  assign m_axi.m_axi_arburst = AXI_BURST_INCR;
  assign m_axi.m_axi_arlock  = AXI_LOCK;
  assign m_axi.m_axi_arcache = AXI_CACHE;
  assign m_axi.m_axi_arprot  = AXI_PROT;
  assign m_axi.m_axi_arqos   = AXI_QOS;
  assign m_axi.m_axi_arvalid = arvalid_q;
  assign m_axi.m_axi_rready  = rready;

endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
// Self-checking bench for painterengine_gpu_dma_reader: AXI memory responder,
// randomised consumer, and a reference of expected bursts and word stream.
module tb_painterengine_gpu_dma_reader;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] length = '0;
  logic        done;
  logic        error;
  logic [2:0]  error_type;
  logic [31:0] data;
  logic        data_valid;
  logic        next = 1'b0;

  painterengine_gpu_dma_reader_if bus ();

  painterengine_gpu_dma_reader #(.PARAM_FIFO_DEPTH(16)) dut (
    .i_wire_clock      (clk),
    .i_wire_resetn     (resetn),
    .i_wire_start      (start),
    .i_wire_address    (address),
    .i_wire_length     (length),
    .o_wire_done       (done),
    .o_wire_error      (error),
    .o_wire_error_type (error_type),
    .o_wire_data       (data),
    .o_wire_data_valid (data_valid),
    .i_wire_data_next  (next),
    .m_axi             (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // scenario knobs
  bit ar_block = 0;
  bit r_gaps = 0;
  bit cons_random = 0;
  int rresp_force = -1;
  int rlast_force = -1;
  int pop_budget = -1;

  // observations
  logic [31:0] ar_seen_addr[$];
  int          ar_seen_len[$];
  logic [31:0] got[$];
  int unsigned last_pop_edge = 0;
  int unsigned done_edge = 0;
  int unsigned s_cyc = 0;

  // expectations
  logic [31:0] exp_addr[$];
  int          exp_len[$];

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Words to the next 64-byte boundary, capped by what remains.
  task automatic model_bursts(input logic [31:0] addr, input int len);
    longint unsigned a;
    int rem, to_boundary, b;
    a = addr;
    rem = len;
    exp_addr.delete();
    exp_len.delete();
    while (rem > 0) begin
      to_boundary = int'((64 - (a % 64)) / 4);
      b = (rem < to_boundary) ? rem : to_boundary;
      exp_addr.push_back(a[31:0]);
      exp_len.push_back(b);
      a = a + 4 * b;
      rem = rem - b;
    end
  endtask

  function automatic int ar_mismatch();
    if (ar_seen_addr.size() != exp_addr.size()) return 1000 + ar_seen_addr.size();
    foreach (exp_addr[i])
      if (ar_seen_addr[i] !== exp_addr[i] || ar_seen_len[i] != exp_len[i]) return i;
    return -1;
  endfunction

  function automatic int stream_mismatch(input logic [31:0] addr, input int len);
    if (got.size() != len) return 100000 + got.size();
    for (int i = 0; i < len; i++)
      if (got[i] !== memword(addr + 32'(4 * i))) return i;
    return -1;
  endfunction

  // AXI memory responder: decides drives at negedge, accounts handshakes at the next.
  initial begin : slave
    logic [31:0] q_addr[$];
    int          q_len[$];
    int          sl_beat;
    int          beat_total;
    bit          ar_hs;
    bit          r_hs;
    logic [31:0] ar_addr_lat;
    int          ar_len_lat;
    sl_beat = 0; beat_total = 0; ar_hs = 0; r_hs = 0; ar_addr_lat = '0; ar_len_lat = 0;
    bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0; bus.m_axi_rdata = '0;
    bus.m_axi_rresp = 2'b00; bus.m_axi_rlast = 1'b0; bus.m_axi_rid = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        q_addr.delete(); q_len.delete();
        sl_beat = 0; beat_total = 0; ar_hs = 0; r_hs = 0;
        bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast = 1'b0; bus.m_axi_rresp = 2'b00;
      end else begin
        if (ar_hs) begin
          q_addr.push_back(ar_addr_lat); q_len.push_back(ar_len_lat);
          ar_seen_addr.push_back(ar_addr_lat); ar_seen_len.push_back(ar_len_lat);
        end
        if (r_hs) begin
          sl_beat++; beat_total++;
          if (sl_beat == q_len[0]) begin
            void'(q_addr.pop_front()); void'(q_len.pop_front()); sl_beat = 0;
          end
        end
        bus.m_axi_arready = !ar_block;
        ar_hs = bus.m_axi_arvalid && bus.m_axi_arready;
        ar_addr_lat = bus.m_axi_araddr;
        ar_len_lat = int'(bus.m_axi_arlen) + 1;
        if (q_len.size() > 0 && (!r_gaps || $urandom_range(0, 3) != 0)) begin
          bus.m_axi_rvalid = 1'b1;
          bus.m_axi_rdata  = memword(q_addr[0] + 32'(4 * sl_beat));
          bus.m_axi_rlast  = (sl_beat == q_len[0] - 1) || (beat_total == rlast_force);
          bus.m_axi_rresp  = (beat_total == rresp_force) ? 2'b10 : 2'b00;
        end else begin
          bus.m_axi_rvalid = 1'b0;
          bus.m_axi_rlast  = 1'b0;
          bus.m_axi_rresp  = 2'b00;
        end
        r_hs = bus.m_axi_rvalid && bus.m_axi_rready;
      end
    end
  end

  // Consumer: pops the head word when allowed and records it.
  initial begin : consumer
    forever begin
      @(negedge clk);
      next = 1'b0;
      if (resetn && data_valid && pop_budget != 0 && (!cons_random || $urandom_range(0, 1) == 1)) begin
        next = 1'b1;
        got.push_back(data);
        last_pop_edge = cyc + 1;
        if (pop_budget > 0) pop_budget--;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete (errors so far %0d)", errors);
    $fatal(1);
  end

  task automatic clear_knobs();
    ar_block = 0; r_gaps = 0; cons_random = 0;
    rresp_force = -1; rlast_force = -1; pop_budget = -1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    resetn = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_xfer(input logic [31:0] addr, input logic [31:0] len);
    @(negedge clk);
    ar_seen_addr.delete(); ar_seen_len.delete(); got.delete();
    address = addr; length = len; start = 1'b1; s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    int n = 0;
    ok = 0;
    while (n < bound) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) begin ok = 1; done_edge = cyc; break; end
      if (error === 1'b1) break;
    end
  endtask

  task automatic wait_error(input int bound, output bit ok);
    int n = 0;
    ok = 0;
    while (n < bound) begin
      @(negedge clk);
      n++;
      if (error === 1'b1) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %0b expected 0", error); end
    checks++; if (error_type !== 3'd0) begin errors++; $display("FAIL reset_error_type: got %0d expected 0", error_type); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %0b expected 0", data_valid); end
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", data); end
    checks++; if (bus.m_axi_arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %0b expected 0", bus.m_axi_arvalid); end
    checks++; if (bus.m_axi_rready !== 1'b0) begin errors++; $display("FAIL reset_rready: got %0b expected 0", bus.m_axi_rready); end
    checks++; if (bus.m_axi_araddr !== 32'h0 || bus.m_axi_arlen !== 8'h0) begin errors++;
      $display("FAIL reset_ar_fields: got addr %h len %0d expected 0/0", bus.m_axi_araddr, bus.m_axi_arlen); end
    checks++; if ({bus.m_axi_arid, bus.m_axi_arsize, bus.m_axi_arburst, bus.m_axi_arlock, bus.m_axi_arcache,
                   bus.m_axi_arprot, bus.m_axi_arqos} !== {1'b0, 3'b010, 2'b01, 1'b0, 4'b0010, 3'b000, 4'b0000}) begin
      errors++; $display("FAIL ar_constants: got size %b burst %b cache %b", bus.m_axi_arsize, bus.m_axi_arburst, bus.m_axi_arcache); end
  endtask

  task automatic test_burst_split();
    bit ok;
    int n = 0;
    int idx;
    clear_knobs();
    model_bursts(32'h1000, 40);
    start_xfer(32'h1000, 40);
    while (bus.m_axi_arvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (cyc - s_cyc != 3) begin errors++; $display("FAIL start_latency: got %0d cycles expected 3", cyc - s_cyc); end
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL split_done: got done=%0b error=%0b expected done", done, error); end
    idx = ar_mismatch();
    checks++; if (idx != -1) begin errors++; $display("FAIL split_ar_list: bad at %0d, got %0d bursts expected %0d", idx, ar_seen_addr.size(), exp_addr.size()); end
    idx = stream_mismatch(32'h1000, 40);
    checks++; if (idx != -1) begin errors++; $display("FAIL split_stream: bad at %0d, got %0d words expected 40", idx, got.size()); end
    checks++; if (done_edge != last_pop_edge + 1) begin errors++; $display("FAIL done_after_pop: got edge %0d expected %0d", done_edge, last_pop_edge + 1); end
  endtask

  task automatic test_unaligned_split();
    bit ok;
    int idx;
    clear_knobs(); r_gaps = 1; cons_random = 1;
    model_bursts(32'h1038, 5);
    start_xfer(32'h1038, 5);
    wait_done(1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL unaligned_done: got done=%0b error=%0b expected done", done, error); end
    checks++; if (ar_seen_addr.size() != 2 || ar_seen_addr[0] !== 32'h1038 || ar_seen_len[0] != 2 ||
                  ar_seen_addr[1] !== 32'h1040 || ar_seen_len[1] != 3) begin
      errors++; $display("FAIL unaligned_ar_list: got %0d bursts expected 0x1038/len1, 0x1040/len2", ar_seen_addr.size()); end
    idx = stream_mismatch(32'h1038, 5);
    checks++; if (idx != -1) begin errors++; $display("FAIL unaligned_stream: bad at %0d, got %0d words expected 5", idx, got.size()); end
  endtask

  task automatic test_consumer_stall();
    bit ok;
    int idx;
    clear_knobs(); pop_budget = 0;
    model_bursts(32'h2000, 40);
    start_xfer(32'h2000, 40);
    repeat (300) @(negedge clk);
    checks++; if (ar_seen_addr.size() != 1 || error !== 1'b0 || data_valid !== 1'b1) begin errors++;
      $display("FAIL stall_hold: got bursts %0d error %0b valid %0b expected 1/0/1", ar_seen_addr.size(), error, data_valid); end
    pop_budget = 15;
    repeat (60) @(negedge clk);
    checks++; if (ar_seen_addr.size() != 1) begin errors++; $display("FAIL stall_15_free: got %0d bursts expected 1", ar_seen_addr.size()); end
    pop_budget = 1;
    repeat (20) @(negedge clk);
    checks++; if (ar_seen_addr.size() != 2) begin errors++; $display("FAIL stall_16_free: got %0d bursts expected 2", ar_seen_addr.size()); end
    pop_budget = -1;
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_done: got done=%0b error=%0b type %0d expected done", done, error, error_type); end
    idx = ar_mismatch();
    checks++; if (idx != -1) begin errors++; $display("FAIL stall_ar_list: bad at %0d", idx); end
    idx = stream_mismatch(32'h2000, 40);
    checks++; if (idx != -1) begin errors++; $display("FAIL stall_stream: bad at %0d, got %0d words expected 40", idx, got.size()); end
  endtask

  task automatic test_random();
    bit ok;
    int idx;
    logic [31:0] a;
    int len;
    for (int t = 0; t < 4; t++) begin
      clear_knobs(); r_gaps = 1; cons_random = 1;
      a = 32'h8000 + 32'(4 * $urandom_range(0, 200));
      len = $urandom_range(1, 60);
      model_bursts(a, len);
      start_xfer(a, 32'(len));
      wait_done(3000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL random_done[%0d]: got done=%0b error=%0b expected done", t, done, error); end
      idx = ar_mismatch();
      checks++; if (idx != -1) begin errors++; $display("FAIL random_ar_list[%0d]: addr %h len %0d bad at %0d", t, a, len, idx); end
      idx = stream_mismatch(a, len);
      checks++; if (idx != -1) begin errors++; $display("FAIL random_stream[%0d]: bad at %0d, got %0d words expected %0d", t, idx, got.size(), len); end
    end
  endtask

  task automatic test_param_errors();
    apply_reset(); clear_knobs();
    start_xfer(32'h1002, 4);
    repeat (20) @(negedge clk);
    checks++; if (error !== 1'b1 || error_type !== 3'd1) begin errors++; $display("FAIL align_error: got error %0b type %0d expected 1/1", error, error_type); end
    checks++; if (ar_seen_addr.size() != 0 || done !== 1'b0) begin errors++; $display("FAIL align_no_ar: got %0d bursts done %0b expected 0/0", ar_seen_addr.size(), done); end
    apply_reset(); clear_knobs();
    start_xfer(32'h1000, 0);
    repeat (20) @(negedge clk);
    checks++; if (error !== 1'b1 || error_type !== 3'd2) begin errors++; $display("FAIL length_error: got error %0b type %0d expected 1/2", error, error_type); end
    checks++; if (ar_seen_addr.size() != 0) begin errors++; $display("FAIL length_no_ar: got %0d bursts expected 0", ar_seen_addr.size()); end
  endtask

  task automatic test_rresp();
    bit ok;
    apply_reset(); clear_knobs(); rresp_force = 3;
    start_xfer(32'h3000, 8);
    wait_error(200, ok);
    checks++; if (!ok || error_type !== 3'd5) begin errors++; $display("FAIL rresp_error: got error %0b type %0d expected 1/5", error, error_type); end
    checks++; if (bus.m_axi_arvalid !== 1'b0 || bus.m_axi_rready !== 1'b0) begin errors++;
      $display("FAIL rresp_quiet: got arvalid %0b rready %0b expected 0/0", bus.m_axi_arvalid, bus.m_axi_rready); end
  endtask

  task automatic test_ar_timeout();
    bit ok;
    int n = 0;
    apply_reset(); clear_knobs(); ar_block = 1;
    start_xfer(32'h1000, 4);
    while (bus.m_axi_arvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    repeat (250) @(negedge clk);
    checks++; if (error !== 1'b0 || bus.m_axi_arvalid !== 1'b1) begin errors++;
      $display("FAIL ar_timeout_early: got error %0b arvalid %0b expected 0/1", error, bus.m_axi_arvalid); end
    wait_error(20, ok);
    checks++; if (!ok || error_type !== 3'd3 || bus.m_axi_arvalid !== 1'b0) begin errors++;
      $display("FAIL ar_timeout: got error %0b type %0d arvalid %0b expected 1/3/0", error, error_type, bus.m_axi_arvalid); end
  endtask

  task automatic test_rlast();
    bit ok;
    apply_reset(); clear_knobs(); rlast_force = 1;
    start_xfer(32'h4000, 4);
    wait_error(200, ok);
    checks++; if (!ok || error_type !== 3'd6 || bus.m_axi_rready !== 1'b0) begin errors++;
      $display("FAIL rlast_error: got error %0b type %0d rready %0b expected 1/6/0", error, error_type, bus.m_axi_rready); end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int n = 0;
    int idx;
    apply_reset(); clear_knobs(); pop_budget = 0;
    start_xfer(32'h5000, 40);
    while (!(data_valid === 1'b1 && bus.m_axi_rready === 1'b1) && n < 50) begin @(negedge clk); n++; end
    checks++; if (n >= 50) begin errors++; $display("FAIL midburst_reach: got no beat within 50 cycles expected data in flight"); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (bus.m_axi_arvalid !== 1'b0 || bus.m_axi_rready !== 1'b0 || data_valid !== 1'b0) begin errors++;
      $display("FAIL midburst_reset_bus: got arvalid %0b rready %0b valid %0b expected 0/0/0", bus.m_axi_arvalid, bus.m_axi_rready, data_valid); end
    checks++; if (done !== 1'b0 || error !== 1'b0 || error_type !== 3'd0 || data !== 32'h0) begin errors++;
      $display("FAIL midburst_reset_status: got done %0b error %0b type %0d data %h expected zeros", done, error, error_type, data); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    clear_knobs();
    start_xfer(32'h6000, 6);
    wait_done(500, ok);
    idx = stream_mismatch(32'h6000, 6);
    checks++; if (!ok || idx != -1) begin errors++; $display("FAIL after_reset_xfer: got done %0b, stream bad at %0d expected clean", ok, idx); end
  endtask

  initial begin : main
    apply_reset();
    test_reset();
    test_burst_split();
    test_unaligned_split();
    test_consumer_stall();
    test_random();
    test_param_errors();
    test_rresp();
    test_ar_timeout();
    test_rlast();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
